inj_arbiter: RTL and testbench
==============================

# inj_arbiter

Round-robin injection arbiter sharing one router injection port among NUM_REQ local requesters (MPI collective engine, reduction-table drain, host send queue, etc.). Each requester presents a packet's header fields and payload; the winner is formatted into the standard 73-bit flit. The block fills in the local source coordinates and the valid bit. The flit is registered and presented to the router with a valid/ready handshake and full backpressure.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- RANK_X / RANK_Y / RANK_Z, 0 / 0 / 0: this node's 3-bit coordinates, inserted as src_x/y/z.
- CNT_W, 16: width of statistics counters (INJ_ARB_STATS_EN only).
- Reset is synchronous, active-low; one clock.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a packet.
- req_ready  out  NUM_REQ  requester i's packet accepted this cycle.
- req_payload  in  NUM_REQ*32  payload, requester i at [32i+31:32i].
- req_op  in  NUM_REQ*4  op field.
- req_algtype  in  NUM_REQ*2  algorithm type.
- req_tag  in  NUM_REQ*8  tag.
- req_ctx  in  NUM_REQ*8  contextId.
- req_dst  in  NUM_REQ*9  {dst_z,dst_y,dst_x}.
- out_flit  out  73  formatted flit: valid[72], dst_z/y/x[71:63], src_z/y/x[62:54], contextId[53:46], tag[45:38], algtype[37:36], op[35:32], payload[31:0].
- out_valid  out  1  out_flit holds a packet.
- out_ready  in  1  router accepts out_flit this cycle.
- gnt_count  out  NUM_REQ*CNT_W  per-requester accepted-packet count.
- stall_count  out  CNT_W  cycles with out_valid=1, out_ready=0.

## Operation
- The output register accepts a new flit when out_valid=0 or out_ready=1. This is the `load` signal.
- On load, if any req_valid is set:
  - Grant the first valid requester at or after the priority pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only; all other req_ready bits are 0.
  - out_flit is formatted from requester g's fields, with src = {RANK_Z,RANK_Y,RANK_X} and bit 72 = 1. out_valid is set to 1.
  - The pointer moves to (g+1) mod NUM_REQ.
- On load with no req_valid set: out_valid goes to 0 and the pointer is unchanged.
- No load (out_valid=1, out_ready=0): out_flit and the pointer hold, and all req_ready bits are 0.
- req_ready is combinational from req_valid, out_valid, out_ready and the pointer. Requesters must not make req_valid depend on req_ready.
- Dst equal to own coordinates: injected unchanged. Loopback is the router's job.
- Fairness: with all requesters continuously valid and out_ready=1, grants cycle 0,1,…,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 grants.

## Timing
- Latency: a packet accepted in cycle t appears on out_flit/out_valid in cycle t+1.
- Throughput: one flit per cycle while out_ready=1 and any requester is valid.
- A back-to-back accept and new load happen in the same cycle. Simultaneous out_ready and a new grant causes no bubble.
- Reset values:
  - out_valid=0, out_flit=0, pointer=0 (requester 0 highest priority).
  - req_ready=0 throughout reset.
  - Counters=0.
- Reset mid-operation: a held flit is discarded and out_valid=0 on the next cycle. No partial state survives.
- Only one packet is granted per cycle.

## Configuration
- INJ_ARB_STATS_EN defined:
  - gnt_count[i] increments on each req_ready[i]&req_valid[i].
  - stall_count increments each cycle with out_valid&~out_ready.
  - All counters saturate at 2^CNT_W-1 and clear only on reset.
- INJ_ARB_STATS_EN undefined: gnt_count and stall_count are present and tied to 0, and no counter flops are built.

## Structure
- Shared package holds the flit layout constants: FLIT_W=73, field positions/widths (payload 0/32, op 32/4, algtype 36/2, tag 38/8, ctx 46/8, src 54/9, dst 63/9, valid 72), and the coordinate width 3.
- Sub-module rr_arbiter (NUM_REQ param):
  - Inputs: req vector, enable (`load`).
  - Outputs: one-hot grant and the grant index.
  - Owns the priority pointer.
- Flit formatting uses the existing packeter module instance, fed by a mux on the grant index.

## Test plan
- Reset, then single requester 2 with payload 0xDEADBEEF, op 3, dst (1,2,3), RANK=(4,5,6), out_ready=1:
  - req_ready[2] pulses once.
  - Next cycle out_flit[72]=1, dst field=0x0D1, src field=0x1AC, payload 0xDEADBEEF, out_valid=1 for one cycle.
- All 4 requesters valid continuously, out_ready=1 → grants in order 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
- Hold out_ready=0 for 5 cycles with out_valid=1:
  - out_flit stable and req_ready=0 throughout.
  - stall_count=5 with INJ_ARB_STATS_EN.
  - On release, the next grant follows the same cycle.
- Requesters 1 and 3 valid, pointer at 2 → requester 3 is granted first, then 1.
- Assert rst_n=0 for one cycle while a flit is held → out_valid=0 and out_flit=0 afterward, and the next grant starts from requester 0.
- Stats build with CNT_W=4: grant requester 0 twenty times → gnt_count[0]=15, saturated.

Source files
------------

// File: rtl/inj_arbiter_pkg.sv
// Shared flit layout for the injection path: field positions, widths, coordinate width.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package inj_arbiter_pkg;

   localparam int FLIT_W      = 73;
   localparam int COORD_W     = 3;

   localparam int PAYLOAD_LSB = 0;
   localparam int PAYLOAD_W   = 32;
   localparam int OP_LSB      = 32;
   localparam int OP_W        = 4;
   localparam int ALG_LSB     = 36;
   localparam int ALG_W       = 2;
   localparam int TAG_LSB     = 38;
   localparam int TAG_W       = 8;
   localparam int CTX_LSB     = 46;
   localparam int CTX_W       = 8;
   localparam int SRC_LSB     = 54;
   localparam int SRC_W       = 3 * COORD_W;
   localparam int DST_LSB     = 63;
   localparam int DST_W       = 3 * COORD_W;
   localparam int VALID_BIT   = 72;

   typedef logic [FLIT_W-1:0] flit_t;

   // Pack x/y/z node coordinates into the {z,y,x} field order used in the flit.
   function automatic logic [SRC_W-1:0] pack_coord(input int x, input int y, input int z);
      logic [COORD_W-1:0] cx;
      logic [COORD_W-1:0] cy;
      logic [COORD_W-1:0] cz;
      cx = COORD_W'(x);
      cy = COORD_W'(y);
      cz = COORD_W'(z);
      return {cz, cy, cx};
   endfunction

endpackage

// File: rtl/inj_arbiter_packeter.sv
// Formats one packet's header fields and payload into a 73-bit flit with the valid bit set.
// Latency: combinational, zero cycles.
// Backpressure: none; purely a field placement function.
module packeter
   import inj_arbiter_pkg::*;
(
   input  logic [PAYLOAD_W-1:0] payload,
   input  logic [OP_W-1:0]      op,
   input  logic [ALG_W-1:0]     algtype,
   input  logic [TAG_W-1:0]     tag,
   input  logic [CTX_W-1:0]     ctx,
   input  logic [DST_W-1:0]     dst,
   input  logic [SRC_W-1:0]     src,
   output flit_t                flit
);

   // Place every field at its fixed position; unused bits stay zero.
   always_comb begin
      flit                              = '0;
      flit[PAYLOAD_LSB +: PAYLOAD_W]    = payload;
      flit[OP_LSB +: OP_W]              = op;
      flit[ALG_LSB +: ALG_W]            = algtype;
      flit[TAG_LSB +: TAG_W]            = tag;
      flit[CTX_LSB +: CTX_W]            = ctx;
      flit[SRC_LSB +: SRC_W]            = src;
      flit[DST_LSB +: DST_W]            = dst;
      flit[VALID_BIT]                   = 1'b1;
   end

endmodule

// File: rtl/inj_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
// Latency: grant combinational; pointer advances on the clock edge of a granted cycle.
// Backpressure: no grant and no pointer movement while enable is low.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      gnt_idx
);

   logic [IW-1:0] ptr;
   logic          found;

   // Search from the pointer upward, wrapping, for the first asserted request.
   always_comb begin
      int j;
      j       = 0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[IW'(j)]) begin
            found   = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

   // One-hot grant only when the consumer can take a packet this cycle.
   always_comb begin
      gnt = '0;
      if (enable && found) gnt[gnt_idx] = 1'b1;
   end

   // Winner drops to lowest priority; an empty cycle leaves the pointer alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (enable && found) begin
         ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/inj_arbiter.sv
// Round-robin injection arbiter: shares one router injection port among NUM_REQ requesters.
// Latency: packet accepted in cycle t is on out_flit/out_valid in cycle t+1.
// Backpressure: output register reloads only when empty or out_ready; req_ready all 0 otherwise.
// Optional statistics counters built only when INJ_ARB_STATS_EN is defined.
module inj_arbiter
   import inj_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int RANK_X  = 0,
   parameter int RANK_Y  = 0,
   parameter int RANK_Z  = 0,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*32-1:0]      req_payload,
   input  logic [NUM_REQ*4-1:0]       req_op,
   input  logic [NUM_REQ*2-1:0]       req_algtype,
   input  logic [NUM_REQ*8-1:0]       req_tag,
   input  logic [NUM_REQ*8-1:0]       req_ctx,
   input  logic [NUM_REQ*9-1:0]       req_dst,
   output logic [FLIT_W-1:0]          out_flit,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_REQ*CNT_W-1:0]   gnt_count,
   output logic [CNT_W-1:0]           stall_count
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [SRC_W-1:0] SRC_COORD = pack_coord(RANK_X, RANK_Y, RANK_Z);

   logic               load;
   logic               any_req;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;

   logic [PAYLOAD_W-1:0] sel_payload;
   logic [OP_W-1:0]      sel_op;
   logic [ALG_W-1:0]     sel_alg;
   logic [TAG_W-1:0]     sel_tag;
   logic [CTX_W-1:0]     sel_ctx;
   logic [DST_W-1:0]     sel_dst;
   flit_t                fmt_flit;

   assign load    = !out_valid || out_ready;
   assign any_req = |req_valid;

   // Handshake is suppressed during reset so nothing is consumed while state is cleared.
   assign req_ready = rst_n ? gnt : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .enable  (load && rst_n),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Steer the winning requester's fields into the formatter.
   always_comb begin
      sel_payload = req_payload[int'(gnt_idx)*PAYLOAD_W +: PAYLOAD_W];
      sel_op      = req_op     [int'(gnt_idx)*OP_W      +: OP_W];
      sel_alg     = req_algtype[int'(gnt_idx)*ALG_W     +: ALG_W];
      sel_tag     = req_tag    [int'(gnt_idx)*TAG_W     +: TAG_W];
      sel_ctx     = req_ctx    [int'(gnt_idx)*CTX_W     +: CTX_W];
      sel_dst     = req_dst    [int'(gnt_idx)*DST_W     +: DST_W];
   end

   packeter u_pack (
      .payload (sel_payload),
      .op      (sel_op),
      .algtype (sel_alg),
      .tag     (sel_tag),
      .ctx     (sel_ctx),
      .dst     (sel_dst),
      .src     (SRC_COORD),
      .flit    (fmt_flit)
   );

   // Output register: reload on accept/empty, go idle if nobody is asking, else hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_flit  <= '0;
      end else if (load) begin
         if (any_req) begin
            out_valid <= 1'b1;
            out_flit  <= fmt_flit;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef INJ_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] gnt_cnt [NUM_REQ];
   logic [CNT_W-1:0] stall_cnt;

   // Saturating per-requester grant and output-stall counters, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_valid[i] && gnt_cnt[i] != CNT_MAX)
               gnt_cnt[i] <= gnt_cnt[i] + 1'b1;
         end
         if (out_valid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Flatten the counter array onto the output bus.
   always_comb begin
      gnt_count = '0;
      for (int i = 0; i < NUM_REQ; i++) gnt_count[i*CNT_W +: CNT_W] = gnt_cnt[i];
   end

   assign stall_count = stall_cnt;
`else
   assign gnt_count   = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_inj_arbiter.sv
// Directed bench for inj_arbiter: reset, formatting, fairness, stall, pointer, reset mid-flight, stats.
// Drives inputs on the falling edge, samples 1 time unit after each edge.
// Expected flits are rebuilt here from the stimulus fields.
module tb_inj_arbiter;

   localparam int N     = 4;
   localparam int CNT_W = 4;
`ifdef INJ_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic               clk;
   logic               rst_n;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*32-1:0]    req_payload;
   logic [N*4-1:0]     req_op;
   logic [N*2-1:0]     req_algtype;
   logic [N*8-1:0]     req_tag;
   logic [N*8-1:0]     req_ctx;
   logic [N*9-1:0]     req_dst;
   logic [72:0]        out_flit;
   logic               out_valid;
   logic               out_ready;
   logic [N*CNT_W-1:0] gnt_count;
   logic [CNT_W-1:0]   stall_count;

   logic [31:0] pay [N];
   logic [3:0]  op  [N];
   logic [1:0]  alg [N];
   logic [7:0]  tag [N];
   logic [7:0]  ctx [N];
   logic [8:0]  dst [N];

   int tests = 0;
   int fails = 0;

   inj_arbiter #(
      .NUM_REQ (N),
      .RANK_X  (4),
      .RANK_Y  (5),
      .RANK_Z  (6),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_payload (req_payload),
      .req_op      (req_op),
      .req_algtype (req_algtype),
      .req_tag     (req_tag),
      .req_ctx     (req_ctx),
      .req_dst     (req_dst),
      .out_flit    (out_flit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .gnt_count   (gnt_count),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack the per-requester field tables onto the flat request buses.
   always_comb begin
      req_payload = '0;
      req_op      = '0;
      req_algtype = '0;
      req_tag     = '0;
      req_ctx     = '0;
      req_dst     = '0;
      for (int i = 0; i < N; i++) begin
         req_payload[i*32 +: 32] = pay[i];
         req_op[i*4 +: 4]        = op[i];
         req_algtype[i*2 +: 2]   = alg[i];
         req_tag[i*8 +: 8]       = tag[i];
         req_ctx[i*8 +: 8]       = ctx[i];
         req_dst[i*9 +: 9]       = dst[i];
      end
   end

   // Expected flit for requester i from this node at (x,y,z)=(4,5,6): src {z,y,x}=0x1AC.
   function automatic logic [72:0] mkflit(input int i);
      return {1'b1, dst[i], 9'h1AC, ctx[i], tag[i], alg[i], op[i], pay[i]};
   endfunction

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_edge();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      drive_edge();
      rst_n = 1'b0;
      step();
      drive_edge();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         pay[i] = 32'h1000_0000 + i;
         op[i]  = 4'(i + 8);
         alg[i] = 2'(i);
         tag[i] = 8'(8'h20 + i);
         ctx[i] = 8'(8'h40 + i);
         dst[i] = 9'(9'h100 + i);
      end

      // Reset: no ready even with every requester asking.
      drive_edge();
      req_valid = 4'hF;
      #1 chk("rst_ready", 128'(req_ready), 128'(4'h0));
      step();
      chk("rst_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_flit", 128'(out_flit), 128'(73'h0));
      chk("rst_stall", 128'(stall_count), 128'(0));
      chk("rst_gnt", 128'(gnt_count), 128'(0));
      drive_edge();
      req_valid = '0;
      rst_n     = 1'b1;

      // Single requester 2, known fields.
      pay[2] = 32'hDEADBEEF;
      op[2]  = 4'd3;
      alg[2] = 2'b10;
      tag[2] = 8'h5A;
      ctx[2] = 8'h3C;
      dst[2] = 9'h0D1;
      step();
      drive_edge();
      req_valid = 4'b0100;
      #1 chk("single_ready", 128'(req_ready), 128'(4'b0100));
      step();
      chk("single_valid", 128'(out_valid), 128'(1'b1));
      chk("single_vbit", 128'(out_flit[72]), 128'(1'b1));
      chk("single_dst", 128'(out_flit[71:63]), 128'(9'h0D1));
      chk("single_src", 128'(out_flit[62:54]), 128'(9'h1AC));
      chk("single_pay", 128'(out_flit[31:0]), 128'(32'hDEADBEEF));
      chk("single_flit", 128'(out_flit), 128'(mkflit(2)));
      drive_edge();
      req_valid = '0;
      #1 chk("single_ready_off", 128'(req_ready), 128'(4'b0000));
      step();
      chk("single_valid_off", 128'(out_valid), 128'(1'b0));

      // Fairness from pointer 0: grants 0,1,2,3,0,1 with no bubbles.
      pay[2] = 32'h1000_0002;
      pulse_reset();
      req_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         #1 chk($sformatf("rr_ready_%0d", k), 128'(req_ready), 128'(4'b0001 << (k % 4)));
         step();
         chk($sformatf("rr_valid_%0d", k), 128'(out_valid), 128'(1'b1));
         chk($sformatf("rr_flit_%0d", k), 128'(out_flit), 128'(mkflit(k % 4)));
         drive_edge();
      end

      // Stall 5 cycles holding requester 1's flit; pointer is now 2.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("stall_ready_%0d", k), 128'(req_ready), 128'(4'b0000));
         step();
         chk($sformatf("stall_flit_%0d", k), 128'(out_flit), 128'(mkflit(1)));
         drive_edge();
      end
      #1 chk("stall_count", 128'(stall_count), STATS ? 128'(5) : 128'(0));

      // Release with only 1 and 3 valid: grant 3 in the release cycle, then 1.
      out_ready = 1'b1;
      req_valid = 4'b1010;
      #1 chk("release_ready3", 128'(req_ready), 128'(4'b1000));
      step();
      chk("release_flit3", 128'(out_flit), 128'(mkflit(3)));
      drive_edge();
      #1 chk("wrap_ready1", 128'(req_ready), 128'(4'b0010));
      step();
      chk("wrap_flit1", 128'(out_flit), 128'(mkflit(1)));

      // Hold a flit, then reset for one cycle.
      drive_edge();
      req_valid = '0;
      out_ready = 1'b0;
      step();
      drive_edge();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      #1 chk("midrst_ready", 128'(req_ready), 128'(4'b0000));
      step();
      chk("midrst_valid", 128'(out_valid), 128'(1'b0));
      chk("midrst_flit", 128'(out_flit), 128'(73'h0));
      drive_edge();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1 chk("midrst_ptr0", 128'(req_ready), 128'(4'b0001));
      step();
      chk("midrst_flit0", 128'(out_flit), 128'(mkflit(0)));

      // Twenty grants to requester 0: counter saturates at 15 with CNT_W=4.
      drive_edge();
      req_valid = '0;
      pulse_reset();
      req_valid = 4'b0001;
      for (int k = 0; k < 20; k++) begin
         step();
         drive_edge();
      end
      req_valid = '0;
      #1;
      chk("sat_gnt0", 128'(gnt_count[3:0]), STATS ? 128'(15) : 128'(0));
      chk("sat_gnt1", 128'(gnt_count[7:4]), 128'(0));
      chk("sat_stall", 128'(stall_count), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
